gray_seq_decoder: RTL and testbench
===================================

// Module: gray_seq_decoder
// PURPOSE
//  Receive end of the Gray-code counter interface. Samples a WIDTH-bit reflected
//  Gray code, converts it to binary, and checks every new sample against the
//  previous one. A legal step is +1 or -1 modulo 2^WIDTH.
//  Reports the count direction, lock status and step errors. Sits between a
//  Gray counter or encoder source and downstream binary logic or a status register.
// PARAMETERS
//  WIDTH      4  Gray/binary word width, >= 2.
//  LOCK_STEPS 2  Consecutive legal steps needed to assert locked, 1..15.
//  ERR_W      8  Width of the saturating error counter.
// PORTS
//  clk        in   1      Clock, rising edge.
//  rst        in   1      Reset: synchronous, active-low.
//  in_valid   in   1      gray_in is sampled on this cycle.
//  gray_in    in   WIDTH  Reflected Gray code input.
//  bin_out    out  WIDTH  Binary equivalent of the last accepted sample (registered).
//  bin_valid  out  1      1-cycle pulse, one cycle after each in_valid.
//  dir_up     out  1      Direction of the last legal step: 1 = +1, 0 = -1.
//  step_err   out  1      1-cycle pulse, coincident with bin_valid, on an illegal step while LOCKED.
//  err_count  out  ERR_W  Number of step_err pulses; saturates at all-ones.
//  locked     out  1      High while the FSM is in LOCKED.
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): bin_out=0, bin_valid=0, dir_up=0, step_err=0,
//    err_count=0, locked=0, FSM=UNLOCKED, run counter=0, prev=0. Reset overrides
//    in_valid in the same cycle. Reset mid-stream discards all history.
//  - Conversion: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. Latency is 1 clk from in_valid
//    to bin_out/bin_valid. No in_valid: bin_out holds and bin_valid=0.
//  - Step classification, cur vs prev (binary), diff=cur-prev mod 2^WIDTH:
//    STAY = diff 0. UP = diff 1. DOWN = diff 2^WIDTH-1. BAD = anything else.
//    A single-bit Gray change is not sufficient on its own: 0000->0010 (0->3) is BAD.
//  - Wrap-around is legal: 1000->0000 (15->0) is UP, and 0000->1000 is DOWN (WIDTH=4).
//  - FSM, evaluated only on in_valid; prev<=cur on every accepted sample:
//    UNLOCKED: store the first sample -> ACQUIRE. No classification is made.
//    ACQUIRE : UP/DOWN -> run++, dir_up updated. When run reaches LOCK_STEPS -> LOCKED.
//              STAY -> no change.
//              BAD -> run=0, stay in ACQUIRE, no step_err.
//              A direction reversal counts as legal and does not reset run.
//    LOCKED  : UP/DOWN -> stay, dir_up updated. STAY -> stay.
//              BAD -> step_err pulse, err_count++ (saturating), run=0, -> ACQUIRE.
//  - locked deasserts in the same cycle that step_err pulses.
//  - At err_count all-ones, a further BAD still pulses step_err; the count holds.
//  - in_valid held high for consecutive cycles: every cycle is a sample.
// STRUCTURE
//  - gray_pkg: FSM state enum {UNLOCKED, ACQUIRE, LOCKED}, step-class enum
//    {STAY, UP, DOWN, BAD}, function gray2bin(WIDTH) (prefix XOR).
//  - Sub-module gray_to_bin: combinational WIDTH-bit converter, also reusable by
//    other blocks. The top level holds the prev register, classifier, FSM, run
//    counter and error counter.
// TESTING
//  1. Reset then feed 0000,0001,0011,0010 with in_valid each cycle ->
//     bin_out 0,1,2,3 one cycle late; locked=1 after sample 3; dir_up=1; err_count=0.
//  2. Locked count-down 0001,0000,1000,1001 -> bin 1,0,15,14; dir_up=0;
//     no step_err at the 0->15 wrap.
//  3. While locked, jump 0000->0010 -> step_err single pulse, err_count=1, locked=0;
//     then 0110,0111 -> locked=1 again after 2 legal steps.
//  4. Repeat sample 0011 five times while locked -> no error; locked stays 1;
//     bin_valid pulses 5 times.
//  5. Force err_count to all-ones via 255 BAD sequences, then one more BAD ->
//     step_err=1, err_count stays 8'hFF.
//  6. Assert rst=0 in the middle of a locked stream with in_valid=1 ->
//     next cycle all outputs are 0 and the FSM is UNLOCKED; the first sample after
//     reset gives no step_err whatever its value.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code receive path.
package gray_pkg;

  // Widest word the generic helper below can convert.
  localparam int GRAY_MAX_W = 32;

  // Width of the consecutive-legal-step run counter (LOCK_STEPS tops out at 15).
  localparam int RUN_W = 4;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } state_e;

  typedef enum logic [1:0] {
    STAY,
    UP,
    DOWN,
    BAD
  } step_e;

  // Prefix-XOR Gray to binary conversion for any zero-extended word up to GRAY_MAX_W bits.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational reflected-Gray to binary converter, WIDTH bits wide.
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign bin[gi] = ^gray[WIDTH-1:gi];
  end

endmodule

// File: rtl/gray_seq_decoder.sv
// Gray-code receive end: converts samples to binary, checks each sample is a
// +/-1 step from the previous one, tracks lock and counts step errors.
module gray_seq_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_STEPS = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             dir_up,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count,
  output logic             locked
);

  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_STEPS);

  logic [WIDTH-1:0] cur_bin;
  logic [WIDTH-1:0] diff;
  step_e            step_cls;
  logic [RUN_W-1:0] run_inc;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] bin_out_q, bin_out_d;
  logic             bin_valid_q, bin_valid_d;
  logic             dir_up_q, dir_up_d;
  logic             step_err_q, step_err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [RUN_W-1:0] run_q, run_d;

  gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
    .gray (gray_in),
    .bin  (cur_bin)
  );

  // Classify the new sample by its modular distance from the previous one.
  always_comb begin
    diff    = cur_bin - prev_q;
    run_inc = run_q + RUN_W'(1);
    if (diff == '0) begin
      step_cls = STAY;
    end else if (diff == WIDTH'(1)) begin
      step_cls = UP;
    end else if (diff == '1) begin
      step_cls = DOWN;
    end else begin
      step_cls = BAD;
    end
  end

  // Next-state and next-output logic; only an accepted sample moves anything.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    bin_out_d   = bin_out_q;
    bin_valid_d = 1'b0;
    dir_up_d    = dir_up_q;
    step_err_d  = 1'b0;
    err_count_d = err_count_q;
    run_d       = run_q;
    if (in_valid) begin
      prev_d      = cur_bin;
      bin_out_d   = cur_bin;
      bin_valid_d = 1'b1;
      case (state_q)
        UNLOCKED: begin
          // First sample has nothing to compare against.
          state_d = ACQUIRE;
          run_d   = '0;
        end
        ACQUIRE: begin
          if (step_cls == UP || step_cls == DOWN) begin
            run_d    = run_inc;
            dir_up_d = (step_cls == UP);
            if (run_inc >= LOCK_RUN) begin
              state_d = LOCKED;
            end
          end else if (step_cls == BAD) begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (step_cls == UP || step_cls == DOWN) begin
            dir_up_d = (step_cls == UP);
          end else if (step_cls == BAD) begin
            step_err_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            run_d   = '0;
            state_d = ACQUIRE;
          end
        end
        default: begin
          state_d = UNLOCKED;
        end
      endcase
    end
  end

  // State and registered outputs; reset clears all history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= UNLOCKED;
      prev_q      <= '0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      dir_up_q    <= 1'b0;
      step_err_q  <= 1'b0;
      err_count_q <= '0;
      run_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      bin_out_q   <= bin_out_d;
      bin_valid_q <= bin_valid_d;
      dir_up_q    <= dir_up_d;
      step_err_q  <= step_err_d;
      err_count_q <= err_count_d;
      run_q       <= run_d;
    end
  end

  assign bin_out   = bin_out_q;
  assign bin_valid = bin_valid_q;
  assign dir_up    = dir_up_q;
  assign step_err  = step_err_q;
  assign err_count = err_count_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_gray_seq_decoder.sv
// Directed testbench for gray_seq_decoder (WIDTH=4, LOCK_STEPS=2, ERR_W=8).
module tb_gray_seq_decoder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] gray_in;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       dir_up;
  logic       step_err;
  logic [7:0] err_count;
  logic       locked;

  int checks = 0;
  int errors = 0;

  gray_seq_decoder #(.WIDTH(4), .LOCK_STEPS(2), .ERR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .gray_in   (gray_in),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .dir_up    (dir_up),
    .step_err  (step_err),
    .err_count (err_count),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample for one cycle, then look at the outputs just after the edge.
  task automatic sample(input logic [3:0] g);
    @(negedge clk);
    in_valid = 1'b1;
    gray_in  = g;
    @(posedge clk);
    #1;
    $display("sample gray=%b -> bin=%0d valid=%0b dir_up=%0b step_err=%0b err_count=%0d locked=%0b",
             g, bin_out, bin_valid, dir_up, step_err, err_count, locked);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    gray_in  = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    if ({bin_out, bin_valid, dir_up, step_err, err_count, locked} !== 16'h0) begin
      $display("FAIL reset_state: got bin=%0d valid=%0b dir=%0b err=%0b cnt=%0d lock=%0b, want all 0",
               bin_out, bin_valid, dir_up, step_err, err_count, locked);
      errors++;
    end
    checks++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_count_up();
    logic [3:0] gv [4];
    logic [3:0] bv [4];
    gv = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
    bv = '{4'd0, 4'd1, 4'd2, 4'd3};
    for (int i = 0; i < 4; i++) begin
      sample(gv[i]);
      if (bin_out !== bv[i] || bin_valid !== 1'b1) begin
        $display("FAIL up_bin[%0d]: got bin=%0d valid=%0b, want bin=%0d valid=1", i, bin_out, bin_valid, bv[i]);
        errors++;
      end
      checks++;
    end
    if (locked !== 1'b1 || dir_up !== 1'b1 || err_count !== 8'd0) begin
      $display("FAIL up_status: got locked=%0b dir_up=%0b err_count=%0d, want 1 1 0", locked, dir_up, err_count);
      errors++;
    end
    checks++;
    idle();
    if (bin_valid !== 1'b0 || bin_out !== 4'd3) begin
      $display("FAIL idle_hold: got bin=%0d valid=%0b, want bin=3 valid=0", bin_out, bin_valid);
      errors++;
    end
    checks++;
  endtask

  task automatic test_count_down_wrap();
    logic [3:0] gv [5];
    logic [3:0] bv [5];
    gv = '{4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b1001};
    bv = '{4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
    for (int i = 0; i < 5; i++) begin
      sample(gv[i]);
      if (bin_out !== bv[i] || step_err !== 1'b0 || locked !== 1'b1 || dir_up !== 1'b0) begin
        $display("FAIL down[%0d]: got bin=%0d step_err=%0b locked=%0b dir_up=%0b, want bin=%0d 0 1 0",
                 i, bin_out, step_err, locked, dir_up, bv[i]);
        errors++;
      end
      checks++;
    end
  endtask

  task automatic test_bad_step_relock();
    sample(4'b1000);
    sample(4'b0000);
    if (locked !== 1'b1 || dir_up !== 1'b1 || bin_out !== 4'd0) begin
      $display("FAIL wrap_up: got locked=%0b dir_up=%0b bin=%0d, want 1 1 0", locked, dir_up, bin_out);
      errors++;
    end
    checks++;
    sample(4'b0010);
    if (step_err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || bin_out !== 4'd3) begin
      $display("FAIL bad_step: got step_err=%0b err_count=%0d locked=%0b bin=%0d, want 1 1 0 3",
               step_err, err_count, locked, bin_out);
      errors++;
    end
    checks++;
    sample(4'b0110);
    if (step_err !== 1'b0 || locked !== 1'b0 || bin_out !== 4'd4) begin
      $display("FAIL relock_1: got step_err=%0b locked=%0b bin=%0d, want 0 0 4", step_err, locked, bin_out);
      errors++;
    end
    checks++;
    sample(4'b0111);
    if (locked !== 1'b1 || err_count !== 8'd1 || bin_out !== 4'd5) begin
      $display("FAIL relock_2: got locked=%0b err_count=%0d bin=%0d, want 1 1 5", locked, err_count, bin_out);
      errors++;
    end
    checks++;
  endtask

  task automatic test_back_to_back_stay();
    int pulses;
    sample(4'b0110);
    sample(4'b0010);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      sample(4'b0011);
      if (bin_valid === 1'b1) pulses++;
      if (step_err !== 1'b0 || locked !== 1'b1 || bin_out !== 4'd2) begin
        $display("FAIL stay[%0d]: got step_err=%0b locked=%0b bin=%0d, want 0 1 2", i, step_err, locked, bin_out);
        errors++;
      end
      checks++;
    end
    if (pulses != 5 || err_count !== 8'd1) begin
      $display("FAIL stay_pulses: got %0d pulses err_count=%0d, want 5 pulses err_count=1", pulses, err_count);
      errors++;
    end
    checks++;
    idle();
  endtask

  task automatic test_err_saturate();
    logic [3:0] v;
    test_reset();
    v = 4'd0;
    sample(v ^ (v >> 1));
    v = v + 4'd1;
    sample(v ^ (v >> 1));
    v = v + 4'd1;
    sample(v ^ (v >> 1));
    for (int r = 1; r <= 255; r++) begin
      v = v + 4'd2;
      sample(v ^ (v >> 1));
      if (step_err !== 1'b1 || err_count !== 8'(r)) begin
        $display("FAIL sat_round[%0d]: got step_err=%0b err_count=%0d, want 1 %0d", r, step_err, err_count, r);
        errors++;
      end
      checks++;
      v = v + 4'd1;
      sample(v ^ (v >> 1));
      v = v + 4'd1;
      sample(v ^ (v >> 1));
    end
    if (err_count !== 8'hFF || locked !== 1'b1) begin
      $display("FAIL sat_full: got err_count=%0h locked=%0b, want ff 1", err_count, locked);
      errors++;
    end
    checks++;
    v = v + 4'd2;
    sample(v ^ (v >> 1));
    if (step_err !== 1'b1 || err_count !== 8'hFF || locked !== 1'b0) begin
      $display("FAIL sat_hold: got step_err=%0b err_count=%0h locked=%0b, want 1 ff 0", step_err, err_count, locked);
      errors++;
    end
    checks++;
    v = v + 4'd1;
    sample(v ^ (v >> 1));
    v = v + 4'd1;
    sample(v ^ (v >> 1));
  endtask

  task automatic test_reset_midstream();
    if (locked !== 1'b1) begin
      $display("FAIL pre_reset_lock: got locked=%0b, want 1", locked);
      errors++;
    end
    checks++;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    gray_in  = 4'b0101;
    @(posedge clk);
    #1;
    if ({bin_out, bin_valid, dir_up, step_err, err_count, locked} !== 16'h0) begin
      $display("FAIL mid_reset: got bin=%0d valid=%0b dir=%0b err=%0b cnt=%0d lock=%0b, want all 0",
               bin_out, bin_valid, dir_up, step_err, err_count, locked);
      errors++;
    end
    checks++;
    @(negedge clk);
    rst = 1'b1;
    sample(4'b0101);
    if (step_err !== 1'b0 || bin_out !== 4'd6 || bin_valid !== 1'b1 || locked !== 1'b0) begin
      $display("FAIL first_after_reset: got step_err=%0b bin=%0d valid=%0b locked=%0b, want 0 6 1 0",
               step_err, bin_out, bin_valid, locked);
      errors++;
    end
    checks++;
    sample(4'b0100);
    if (locked !== 1'b0 || bin_out !== 4'd7) begin
      $display("FAIL reacq_1: got locked=%0b bin=%0d, want 0 7", locked, bin_out);
      errors++;
    end
    checks++;
    sample(4'b1100);
    if (locked !== 1'b1 || bin_out !== 4'd8 || dir_up !== 1'b1 || err_count !== 8'd0) begin
      $display("FAIL reacq_2: got locked=%0b bin=%0d dir_up=%0b err_count=%0d, want 1 8 1 0",
               locked, bin_out, dir_up, err_count);
      errors++;
    end
    checks++;
    idle();
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    gray_in  = 4'b0000;
    test_reset();
    test_count_up();
    test_count_down_wrap();
    test_bad_step_relock();
    test_back_to_back_stay();
    test_err_saturate();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
